// File: rtl/plab4_net_router_adaptive_input_ctrl_pkt_if.sv
// Input-port bundle between the upstream flit source and the router input controller.
// Carries the flit control fields, downstream credit/occupancy hints and allocator request/grant.
// master = upstream/allocator side, slave = input controller.
interface plab4_net_router_adaptive_input_ctrl_pkt_if #(
    parameter int p_num_routers         = 8,
    parameter int p_num_free_nbits      = 2,
    parameter int p_num_free_chan_nbits = 2
);
    localparam int c_dest_nbits = $clog2(p_num_routers);

    logic [c_dest_nbits-1:0]          dest;
    logic                             in_val;
    logic                             head;
    logic                             tail;
    logic                             in_rdy;
    logic [p_num_free_nbits-1:0]      num_free_prev;
    logic [p_num_free_nbits-1:0]      num_free_next;
    logic [p_num_free_chan_nbits-1:0] num_free_chan_prev;
    logic [p_num_free_chan_nbits-1:0] num_free_chan_next;
    logic [2:0]                       reqs;
    logic [2:0]                       grants;
    logic                             domain;
    logic                             pkt_domain;
    logic                             starve;

    modport master (
        output dest, in_val, head, tail,
        output num_free_prev, num_free_next, num_free_chan_prev, num_free_chan_next,
        output grants, domain,
        input  in_rdy, reqs, pkt_domain, starve
    );

    modport slave (
        input  dest, in_val, head, tail,
        input  num_free_prev, num_free_next, num_free_chan_prev, num_free_chan_next,
        input  grants, domain,
        output in_rdy, reqs, pkt_domain, starve
    );
endinterface

// File: rtl/plab4_net_router_adaptive_input_ctrl_pkt.sv
// Purpose: packet-level input controller for a bidirectional ring router; routes each packet
//          on its head flit (shortest path, occupancy tie-break) and locks the route for the body.
// Latency: head flit is requested one cycle after it is first seen; body flits are requested at once.
// Backpressure: in_rdy = |(reqs & grants); PREV/NEXT requests are withheld while downstream credits
//          are at or below p_free_thresh. Optional stall-driven reroute of a waiting head is enabled
//          by defining PLAB4_NET_ROUTER_ADAPTIVE_STARVE_EN (default build: starve tied low).
module plab4_net_router_adaptive_input_ctrl_pkt #(
    parameter int p_router_id           = 0,
    parameter int p_num_routers         = 8,
    parameter int p_num_free_nbits      = 2,
    parameter int p_num_free_chan_nbits = 2,
    parameter int p_free_thresh         = 1,
    parameter int p_starve_limit        = 8
) (
    input logic clk,
    input logic reset,
    plab4_net_router_adaptive_input_ctrl_pkt_if.slave bus
);
    localparam int c_dest_nbits = $clog2(p_num_routers);
    localparam int c_dist_nbits = c_dest_nbits + 1;
    localparam logic [c_dist_nbits-1:0]     c_n      = c_dist_nbits'(p_num_routers);
    localparam logic [c_dist_nbits-1:0]     c_id     = c_dist_nbits'(p_router_id % p_num_routers);
    localparam logic [p_num_free_nbits-1:0] c_thresh = p_num_free_nbits'(p_free_thresh);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BODY} state_e;
    // Encoding equals the bit index of the matching request line.
    typedef enum logic [1:0] {RT_PREV = 2'd0, RT_TERM = 2'd1, RT_NEXT = 2'd2} route_e;

    state_e state;
    state_e state_next;
    route_e route_reg;
    route_e route_calc;
    logic   pkt_domain_reg;
    logic [2:0] reqs;
    logic   in_rdy;
    logic   xfer;
    logic   capture;
    logic [c_dist_nbits-1:0] dist_sum;
    logic [c_dist_nbits-1:0] dn;
    logic [c_dist_nbits-1:0] dp;
    logic [c_dest_nbits-1:0] dest;
    logic [p_num_free_chan_nbits-1:0] chan_prev;
    logic [p_num_free_chan_nbits-1:0] chan_next;

    assign dest      = bus.dest;
    assign chan_prev = bus.num_free_chan_prev;
    assign chan_next = bus.num_free_chan_next;

    // Route for a new head: hop distances both ways round the ring, shorter wins.
    always_comb begin
        dist_sum   = {1'b0, dest} + c_n - c_id;
        dn         = (dist_sum >= c_n) ? (dist_sum - c_n) : dist_sum;
        dp         = c_n - dn;
        route_calc = RT_TERM;
        if (dn == '0)
            route_calc = RT_TERM;
        else if (dn < dp)
            route_calc = RT_NEXT;
        else if (dn > dp)
            route_calc = RT_PREV;
        else if (chan_prev > chan_next)
            route_calc = RT_PREV;
        else
            route_calc = RT_NEXT;
    end

    // Next-state, credit-gated requests and the transfer handshake.
    always_comb begin
        state_next = state;
        reqs       = '0;
        in_rdy     = 1'b0;
        xfer       = 1'b0;
        capture    = 1'b0;

        if (state != ST_IDLE && bus.in_val) begin
            case (route_reg)
                RT_PREV: reqs[0] = (bus.num_free_prev > c_thresh);
                RT_TERM: reqs[1] = 1'b1;
                RT_NEXT: reqs[2] = (bus.num_free_next > c_thresh);
                default: reqs    = '0;
            endcase
        end

        in_rdy = |(reqs & bus.grants);
        xfer   = bus.in_val & in_rdy;

        case (state)
            ST_IDLE: begin
                if (bus.in_val && bus.head) begin
                    capture    = 1'b1;
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (xfer)
                    state_next = bus.tail ? ST_IDLE : ST_BODY;
            end
            ST_BODY: begin
                if (xfer && bus.tail)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM state register; reset abandons any packet in flight.
    always_ff @(posedge clk) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

`ifdef PLAB4_NET_ROUTER_ADAPTIVE_STARVE_EN
    localparam int c_cnt_nbits = $clog2(p_starve_limit + 1);
    localparam logic [c_cnt_nbits-1:0] c_limit    = c_cnt_nbits'(p_starve_limit);
    localparam logic [c_cnt_nbits-1:0] c_limit_m1 = c_cnt_nbits'(p_starve_limit - 1);
    localparam logic [c_cnt_nbits-1:0] c_cnt_one  = c_cnt_nbits'(1);

    logic [c_cnt_nbits-1:0] stall_cnt;
    logic stalled;
    logic reroute;
    logic starve_reg;

    // A waiting head that keeps losing flips direction once the stall budget is spent.
    always_comb begin
        stalled = (state == ST_WAIT) && bus.in_val && !in_rdy;
        reroute = stalled && (stall_cnt == c_limit_m1) && (route_reg != RT_TERM);
    end

    // Saturating stall counter and one-cycle starve pulse.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt  <= '0;
            starve_reg <= 1'b0;
        end else begin
            starve_reg <= reroute;
            if (capture || reroute)
                stall_cnt <= '0;
            else if (stalled && stall_cnt != c_limit)
                stall_cnt <= stall_cnt + c_cnt_one;
        end
    end

    assign bus.starve = starve_reg;
`else
    assign bus.starve = 1'b0;
`endif

    // Route is chosen on the head and then held for the packet (except a starve reroute).
    always_ff @(posedge clk) begin
        if (!reset)
            route_reg <= RT_TERM;
        else if (capture)
            route_reg <= route_calc;
`ifdef PLAB4_NET_ROUTER_ADAPTIVE_STARVE_EN
        else if (reroute)
            route_reg <= (route_reg == RT_PREV) ? RT_NEXT : RT_PREV;
`endif
    end

    // Security domain travels with the packet from its head.
    always_ff @(posedge clk) begin
        if (!reset)
            pkt_domain_reg <= 1'b0;
        else if (capture)
            pkt_domain_reg <= bus.domain;
    end

    assign bus.reqs       = reqs;
    assign bus.in_rdy     = in_rdy;
    assign bus.pkt_domain = pkt_domain_reg;
endmodule

// File: tb/tb_plab4_net_router_adaptive_input_ctrl_pkt.sv
// Self-checking bench for the ring input controller at router 2 of 8.
// Expected request vector and packet domain are queued per flit and checked at transfer time.
module tb_plab4_net_router_adaptive_input_ctrl_pkt;
    logic clk;
    logic reset;

    plab4_net_router_adaptive_input_ctrl_pkt_if #(
        .p_num_routers(8), .p_num_free_nbits(2), .p_num_free_chan_nbits(2)
    ) bus ();

    plab4_net_router_adaptive_input_ctrl_pkt #(
        .p_router_id(2), .p_num_routers(8), .p_num_free_nbits(2),
        .p_num_free_chan_nbits(2), .p_free_thresh(1), .p_starve_limit(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] reqs;
        logic       dom;
    } exp_t;

    typedef struct packed {
        logic [2:0] dest;
        logic [1:0] chp;
        logic [1:0] chn;
        logic [2:0] gnt;
        logic [2:0] nfl;
        logic [2:0] exp;
        logic       dom;
    } pkt_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.in_val = 1'b0;
        bus.head   = 1'b0;
        bus.tail   = 1'b0;
        bus.grants = 3'b000;
    endtask

    // Scoreboard: every transfer pops one expectation.
    always @(negedge clk) begin
        if (reset && bus.in_val && bus.in_rdy) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", sb.size(), 1);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("xfer_reqs", bus.reqs, e.reqs);
                chk("xfer_dom", bus.pkt_domain, e.dom);
            end
        end
    end

    // Present one flit (called just after a rising edge) and wait for it to transfer.
    task automatic xfer_flit(input logic hd, input logic tl, input logic [2:0] er,
                             input logic ed, input logic [2:0] gnt, output int waited);
        exp_t e;
        bit   ok;
        ok     = 1'b0;
        waited = -1;
        e.reqs = er;
        e.dom  = ed;
        sb.push_back(e);
        bus.head   = hd;
        bus.tail   = tl;
        bus.grants = gnt;
        bus.in_val = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.in_rdy) begin
                ok     = 1'b1;
                waited = i;
            end
        end
        chk("xfer_seen", ok, 1);
        if (!ok && sb.size() > 0) sb.delete(sb.size() - 1);
        tick();
    endtask

    task automatic check_idle(input string tag);
        bus.in_val = 1'b1;
        bus.head   = 1'b0;
        bus.tail   = 1'b0;
        bus.grants = 3'b111;
        @(negedge clk);
        chk(tag, bus.reqs, 0);
        chk({tag, "_rdy"}, bus.in_rdy, 0);
        idle_bus();
        tick();
    endtask

    task automatic send_pkt(input pkt_t p);
        int w;
        bus.num_free_prev      = 2'd3;
        bus.num_free_next      = 2'd3;
        bus.num_free_chan_prev = p.chp;
        bus.num_free_chan_next = p.chn;
        for (int f = 0; f < int'(p.nfl); f++) begin
            // Body flits carry misleading dest/domain/head; the locked route must ignore them.
            bus.dest   = (f == 0) ? p.dest : p.dest + 3'd3;
            bus.domain = (f == 0) ? p.dom : ~p.dom;
            if (f > 0) begin
                bus.num_free_chan_prev = p.chn;
                bus.num_free_chan_next = p.chp;
            end
            xfer_flit((f == 0) || (f == 1 && p.nfl > 3'd2), (f == int'(p.nfl) - 1),
                      p.exp, p.dom, p.gnt, w);
            if (f == 0) chk("head_lat", w, 1);
            else        chk("body_lat", w, 0);
        end
        idle_bus();
        check_idle("idle_after_pkt");
    endtask

    // Credit gating: low credits withhold the request, raised credits release it.
    task automatic gate_test(input logic [2:0] d, input logic [2:0] er);
        int w;
        bus.dest          = d;
        bus.domain        = 1'b0;
        bus.num_free_prev = 2'd1;
        bus.num_free_next = 2'd1;
        bus.head          = 1'b1;
        bus.tail          = 1'b1;
        bus.grants        = er;
        bus.in_val        = 1'b1;
        tick();
        @(negedge clk);
        chk("gate_lo_reqs", bus.reqs, 0);
        chk("gate_lo_rdy", bus.in_rdy, 0);
        bus.num_free_prev = 2'd2;
        bus.num_free_next = 2'd2;
        bus.grants        = ~er;
        #1;
        chk("gate_hi_reqs", bus.reqs, er);
        chk("nonreq_grant_rdy", bus.in_rdy, 0);
        tick();
        xfer_flit(1'b1, 1'b1, er, 1'b0, er, w);
        chk("gate_xfer_lat", w, 0);
        idle_bus();
        check_idle("idle_after_gate");
    endtask

    pkt_t tbl [8];

    initial begin
        int w;
        int pulses;
        int first;
        logic [2:0] er;

        tbl[0] = '{3'd2, 2'd0, 2'd0, 3'b010, 3'd1, 3'b010, 1'b1}; // local delivery
        tbl[1] = '{3'd6, 2'd3, 2'd1, 3'b001, 3'd1, 3'b001, 1'b0}; // tie, prev emptier
        tbl[2] = '{3'd6, 2'd2, 2'd2, 3'b100, 3'd1, 3'b100, 1'b1}; // tie, equal -> next
        tbl[3] = '{3'd6, 2'd0, 2'd2, 3'b100, 3'd1, 3'b100, 1'b0}; // tie, next emptier
        tbl[4] = '{3'd4, 2'd0, 2'd0, 3'b100, 3'd4, 3'b100, 1'b1}; // 4-flit on next
        tbl[5] = '{3'd1, 2'd0, 2'd0, 3'b001, 3'd2, 3'b001, 1'b0}; // 7 vs 1 hop -> prev
        tbl[6] = '{3'd3, 2'd1, 2'd3, 3'b100, 3'd1, 3'b100, 1'b0}; // 1 hop -> next
        tbl[7] = '{3'd0, 2'd0, 2'd0, 3'b011, 3'd3, 3'b001, 1'b1}; // prev, extra grant bit

        // Reset with an eager head and all grants present.
        reset                  = 1'b0;
        bus.dest               = 3'd4;
        bus.domain             = 1'b1;
        bus.num_free_prev      = 2'd3;
        bus.num_free_next      = 2'd3;
        bus.num_free_chan_prev = 2'd0;
        bus.num_free_chan_next = 2'd0;
        bus.in_val             = 1'b1;
        bus.head               = 1'b1;
        bus.tail               = 1'b1;
        bus.grants             = 3'b111;
        tick();
        tick();
        @(negedge clk);
        chk("rst_reqs", bus.reqs, 0);
        chk("rst_rdy", bus.in_rdy, 0);
        chk("rst_dom", bus.pkt_domain, 0);
        chk("rst_starve", bus.starve, 0);
        idle_bus();
        tick();
        reset = 1'b1;
        tick();

        foreach (tbl[k]) send_pkt(tbl[k]);

        gate_test(3'd5, 3'b100);
        gate_test(3'd0, 3'b001);

        // Head stuck on NEXT with no grants.
        bus.dest          = 3'd4;
        bus.domain        = 1'b1;
        bus.num_free_prev = 2'd3;
        bus.num_free_next = 2'd3;
        bus.grants        = 3'b000;
        bus.head          = 1'b1;
        bus.tail          = 1'b1;
        bus.in_val        = 1'b1;
        tick();
        pulses = 0;
        first  = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 0) chk("stall_reqs", bus.reqs, 3'b100);
            if (bus.starve) begin
                pulses++;
                if (first < 0) first = i;
            end
        end
`ifdef PLAB4_NET_ROUTER_ADAPTIVE_STARVE_EN
        chk("starve_pulses", pulses, 1);
        chk("starve_cycle", first, 8);
        chk("reroute_reqs", bus.reqs, 3'b001);
        er = 3'b001;
`else
        chk("starve_pulses", pulses, 0);
        chk("route_held", bus.reqs, 3'b100);
        er = 3'b100;
`endif
        tick();
        xfer_flit(1'b1, 1'b1, er, 1'b1, er, w);
        chk("stall_xfer_lat", w, 0);
        idle_bus();
        check_idle("idle_after_stall");

        // Reset in the middle of a packet body.
        bus.dest   = 3'd4;
        bus.domain = 1'b1;
        xfer_flit(1'b1, 1'b0, 3'b100, 1'b1, 3'b100, w);
        xfer_flit(1'b0, 1'b0, 3'b100, 1'b1, 3'b100, w);
        reset      = 1'b0;
        bus.in_val = 1'b0;
        tick();
        bus.in_val = 1'b1;
        bus.head   = 1'b0;
        bus.grants = 3'b111;
        @(negedge clk);
        chk("midrst_reqs", bus.reqs, 0);
        chk("midrst_rdy", bus.in_rdy, 0);
        chk("midrst_dom", bus.pkt_domain, 0);
        chk("midrst_starve", bus.starve, 0);
        tick();
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_idle", bus.reqs, 0);
        idle_bus();
        tick();

        // A fresh packet works after the abandoned one.
        send_pkt(tbl[0]);

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
